// File: rtl/rv32i_core.sv
// Single-cycle RV32I core with a unified 4096-word BIOS memory.
// The register file and the memory are separate modules so a bench can reach their arrays by instance name.
module rv32i_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wdata
);
  logic [31:0] regs [0:31];

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (we && wa != 5'd0) begin
      regs[wa] <= wdata;
    end
  end
endmodule

module rv32i_bios_mem (
  input  logic        clk,
  input  logic [11:0] iaddr,
  output logic [31:0] idata,
  input  logic [11:0] daddr,
  output logic [31:0] ddata,
  input  logic [3:0]  we,
  input  logic [31:0] wdata
);
  logic [31:0] mem [0:4095];

  assign idata = mem[iaddr];
  assign ddata = mem[daddr];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (we[b]) mem[daddr][8*b +: 8] <= wdata[8*b +: 8];
  end
endmodule

module rv32i_core #(
  parameter int unsigned CPU_CLOCK_FREQ = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] wd,
  input  logic        FPGA_SERIAL_RX,
  output logic        FPGA_SERIAL_TX
);
  logic [31:0] pc, pc4, pc_next, inst, rs1v, rs2v, ddata;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, addr, alu_b, alu_out, ld_data, lshift;
  logic [31:0] wd_c, mem_wdata;
  logic [3:0]  mem_we;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic        rf_we, take, ld_ok;
  logic        unused_ok;

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign f3     = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign pc4    = pc + 32'd4;

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'd0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  assign addr   = rs1v + ((opcode == 7'h23) ? imm_s : imm_i);
  assign lshift = ddata >> {addr[1:0], 3'b000};
  assign alu_b  = (opcode == 7'h33) ? rs2v : imm_i;

  assign FPGA_SERIAL_TX = 1'b1;
  assign wd = rst ? 32'd0 : wd_c;
  assign unused_ok = ^{FPGA_SERIAL_RX, pc[1:0], pc[31:14], addr[31:14], 32'(CPU_CLOCK_FREQ)};

  rv32i_regfile rf (
    .clk(clk), .rst(rst), .ra1(rs1), .ra2(rs2), .rd1(rs1v), .rd2(rs2v),
    .we(rf_we), .wa(rd), .wdata(wd_c)
  );

  rv32i_bios_mem bios_mem (
    .clk(clk), .iaddr(pc[13:2]), .idata(inst), .daddr(addr[13:2]), .ddata(ddata),
    .we(rst ? 4'd0 : mem_we), .wdata(mem_wdata)
  );

  // ALU shared by OP and OP-IMM; inst[30] selects SUB/SRA in both forms (never SUB for immediates)
  always_comb begin
    alu_out = 32'd0;
    case (f3)
      3'b000: alu_out = (opcode == 7'h33 && inst[30]) ? rs1v - alu_b : rs1v + alu_b;
      3'b001: alu_out = rs1v << alu_b[4:0];
      3'b010: alu_out = 32'($signed(rs1v) < $signed(alu_b));
      3'b011: alu_out = 32'(rs1v < alu_b);
      3'b100: alu_out = rs1v ^ alu_b;
      3'b101: alu_out = inst[30] ? 32'($signed(rs1v) >>> alu_b[4:0]) : rs1v >> alu_b[4:0];
      3'b110: alu_out = rs1v | alu_b;
      default: alu_out = rs1v & alu_b;
    endcase
  end

  always_comb begin
    ld_data = 32'd0;
    ld_ok   = 1'b1;
    case (f3)
      3'b000: ld_data = {{24{lshift[7]}}, lshift[7:0]};
      3'b001: ld_data = {{16{lshift[15]}}, lshift[15:0]};
      3'b010: ld_data = ddata;
      3'b100: ld_data = {24'd0, lshift[7:0]};
      3'b101: ld_data = {16'd0, lshift[15:0]};
      default: ld_ok = 1'b0;
    endcase
  end

  always_comb begin
    take = 1'b0;
    case (f3)
      3'b000: take = (rs1v == rs2v);
      3'b001: take = (rs1v != rs2v);
      3'b100: take = ($signed(rs1v) < $signed(rs2v));
      3'b101: take = ($signed(rs1v) >= $signed(rs2v));
      3'b110: take = (rs1v < rs2v);
      3'b111: take = (rs1v >= rs2v);
      default: take = 1'b0;
    endcase
  end

  // Decode: anything unrecognised falls through as a NOP with PC+4
  always_comb begin
    rf_we     = 1'b0;
    wd_c      = alu_out;
    pc_next   = pc4;
    mem_we    = 4'd0;
    mem_wdata = rs2v << {addr[1:0], 3'b000};
    case (opcode)
      7'h37: begin rf_we = 1'b1; wd_c = imm_u; end
      7'h17: begin rf_we = 1'b1; wd_c = pc + imm_u; end
      7'h6F: begin rf_we = 1'b1; wd_c = pc4; pc_next = pc + imm_j; end
      7'h67: if (f3 == 3'b000) begin
        rf_we = 1'b1; wd_c = pc4; pc_next = (rs1v + imm_i) & ~32'd1;
      end
      7'h63: if (take) pc_next = pc + imm_b;
      7'h03: begin rf_we = ld_ok; wd_c = ld_data; end
      7'h23: case (f3)
        3'b000: mem_we = 4'b0001 << addr[1:0];
        3'b001: mem_we = 4'b0011 << {addr[1], 1'b0};
        3'b010: mem_we = 4'b1111;
        default: mem_we = 4'd0;
      endcase
      7'h13, 7'h33: rf_we = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= 32'd0;
    else     pc <= pc_next;
  end
endmodule

// File: tb/tb_rv32i_core.sv
// Directed-program bench: expected register write-backs are queued, a negedge monitor checks each retirement.
module tb_rv32i_core;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic        tx;
  logic [31:0] wd;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] val;
  } wb_t;

  wb_t          exp_q[$];
  logic [31:0]  prog [0:34];

  rv32i_core #(.CPU_CLOCK_FREQ(50_000_000)) dut (
    .clk(clk), .rst(rst), .wd(wd), .FPGA_SERIAL_RX(rx), .FPGA_SERIAL_TX(tx)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] val);
    wb_t e;
    e.rd = rd;
    e.val = val;
    exp_q.push_back(e);
  endtask

  // Hand-computed write-back sequence of the program, in retirement order
  task automatic push_program;
    push(10, 32'd100);  push(2, 32'd200);  push(1, 32'd300);  push(20, 32'd1);
    push(1, 32'd500);   push(2, 32'd100);  push(20, 32'd2);   push(3, 32'd7);
    push(5, 32'd48);    push(7, 32'd9);    push(8, 32'd64);   push(6, 32'd1);
    push(11, 32'hDEADC000); push(11, 32'hDEADBEEF); push(12, 32'h400);
    push(13, 32'hFFFFFFDE); push(14, 32'h000000DE); push(15, 32'h5A5);
    push(16, 32'h05A5BEEF); push(17, 32'h5A5); push(18, 32'hFFFFFFEF);
    push(19, 32'hFFFFFFA3); push(21, 32'd1); push(22, 32'd0);
    push(23, 32'hFFFFFFE8); push(24, 32'hF); push(20, 32'd3);
  endtask

  task automatic chk_reset_state(input string tag);
    logic [31:0] nz = 32'd0;
    for (int i = 0; i < 32; i++) if (dut.rf.regs[i] !== 32'd0) nz[i] = 1'b1;
    chk({tag, "_regs_nonzero_mask"}, nz, 32'd0);
    chk({tag, "_pc"}, dut.pc, 32'd0);
    chk({tag, "_wd"}, wd, 32'd0);
    chk({tag, "_tx"}, 32'(tx), 32'd1);
  endtask

  task automatic drain_and_check(input string tag);
    for (int c = 0; c < 500 && exp_q.size() != 0; c++) @(negedge clk);
    chk({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    chk({tag, "_pc_halt"}, dut.pc, 32'd136);
    chk({tag, "_x0"}, dut.rf.regs[0], 32'd0);
    chk({tag, "_x1"}, dut.rf.regs[1], 32'd500);
    chk({tag, "_x2"}, dut.rf.regs[2], 32'd100);
    chk({tag, "_x10"}, dut.rf.regs[10], 32'd100);
    chk({tag, "_x20"}, dut.rf.regs[20], 32'd3);
    chk({tag, "_mem_word"}, dut.bios_mem.mem[256], 32'h05A5BEEF);
  endtask

  // Monitor: every non-x0 retirement must match the head of the queue
  always @(negedge clk) begin
    if (!rst && dut.rf_we && dut.rd != 5'd0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got rd=%0d wd=%h expected no write", dut.rd, wd);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        if (dut.rd !== e.rd || wd !== e.val) begin
          errors++;
          $display("FAIL writeback: got rd=%0d wd=%h expected rd=%0d wd=%h", dut.rd, wd, e.rd, e.val);
        end
      end
    end
  end

  initial begin
    prog[0]  = enc_i(12'd100, 0, 3'b000, 10, 7'h13);
    prog[1]  = enc_i(12'd200, 0, 3'b000, 2, 7'h13);
    prog[2]  = enc_r(7'h00, 2, 10, 3'b000, 1);
    prog[3]  = enc_i(12'd1, 0, 3'b000, 20, 7'h13);
    prog[4]  = enc_b(13'd8, 10, 10, 3'b000);
    prog[5]  = enc_i(12'd13, 0, 3'b000, 1, 7'h13);
    prog[6]  = enc_i(12'd500, 0, 3'b000, 1, 7'h13);
    prog[7]  = enc_i(12'd100, 0, 3'b000, 2, 7'h13);
    prog[8]  = enc_i(12'd2, 0, 3'b000, 20, 7'h13);
    prog[9]  = enc_b(13'd8, 10, 10, 3'b001);
    prog[10] = enc_i(12'd7, 0, 3'b000, 3, 7'h13);
    prog[11] = enc_j(21'd12, 5);
    prog[12] = enc_i(12'd1, 0, 3'b000, 6, 7'h13);
    prog[13] = enc_j(21'd12, 0);
    prog[14] = enc_i(12'd9, 0, 3'b000, 7, 7'h13);
    prog[15] = enc_i(12'd1, 5, 3'b000, 8, 7'h67);
    prog[16] = {20'hDEADC, 5'd11, 7'h37};
    prog[17] = enc_i(12'hEEF, 11, 3'b000, 11, 7'h13);
    prog[18] = enc_i(12'h400, 0, 3'b000, 12, 7'h13);
    prog[19] = enc_s(12'd0, 11, 12, 3'b010);
    prog[20] = enc_i(12'd3, 12, 3'b000, 13, 7'h03);
    prog[21] = enc_i(12'd3, 12, 3'b100, 14, 7'h03);
    prog[22] = enc_i(12'h5A5, 0, 3'b000, 15, 7'h13);
    prog[23] = enc_s(12'd2, 15, 12, 3'b001);
    prog[24] = enc_i(12'd0, 12, 3'b010, 16, 7'h03);
    prog[25] = enc_i(12'd2, 12, 3'b001, 17, 7'h03);
    prog[26] = enc_i(12'd0, 12, 3'b000, 18, 7'h03);
    prog[27] = enc_i(12'd5, 0, 3'b000, 0, 7'h13);
    prog[28] = enc_r(7'h20, 10, 3, 3'b000, 19);
    prog[29] = enc_r(7'h00, 3, 19, 3'b010, 21);
    prog[30] = enc_r(7'h00, 3, 19, 3'b011, 22);
    prog[31] = enc_i({7'h20, 5'd2}, 19, 3'b101, 23, 7'h13);
    prog[32] = enc_i({7'h00, 5'd28}, 19, 3'b101, 24, 7'h13);
    prog[33] = enc_i(12'd3, 0, 3'b000, 20, 7'h13);
    prog[34] = enc_j(21'd0, 0);
    for (int i = 0; i < 512; i++)
      dut.bios_mem.mem[i] <= (i < 35) ? prog[i] : 32'd0;

    repeat (30) @(negedge clk);
    chk_reset_state("reset");

    push_program();
    @(posedge clk); #2 rst = 1'b0;
    drain_and_check("run1");

    // Mid-run reset: let three instructions be presented, then abort the third
    @(negedge clk); #2 rst = 1'b1;
    @(negedge clk);
    push_program();
    @(posedge clk); #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    exp_q.delete();
    #1 chk_reset_state("midrun");
    repeat (2) @(negedge clk);
    chk("midrun_x1_aborted", dut.rf.regs[1], 32'd0);

    push_program();
    @(posedge clk); #2 rst = 1'b0;
    drain_and_check("run2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
